// File: rtl/dsp_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   - default parameter values (address/instruction width, reset PC, queue depth)
//   - fetch FSM state encoding (HOLD / RUN / FLUSH, 2 bits)
//   - counter width helper
package dsp_fetch_pkg;

  localparam int unsigned ADDR_W_DEF   = 16;
  localparam int unsigned INSTR_W_DEF  = 16;
  localparam int unsigned RESET_PC_DEF = 0;
  localparam int unsigned QDEPTH_DEF   = 2;
  localparam int unsigned PERF_W       = 16;

  typedef enum logic [1:0] {
    FETCH_ST_HOLD  = 2'd0,
    FETCH_ST_RUN   = 2'd1,
    FETCH_ST_FLUSH = 2'd2
  } fetch_state_e;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dsp_fetch_if.sv
// Fetch-stage bus bundle: instruction memory request/response channel plus
// the decode-facing instruction channel.
//   master : fetch stage (drives requests and instructions)
//   slave  : memory + decode side
interface dsp_fetch_if #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned INSTR_W = 16
);

  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;

  modport master (
    output imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
  );

endinterface

// File: rtl/dsp_fetch_queue.sv
// Synchronous FIFO used for the instruction queue and the pc shadow FIFO.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset (also clears storage)
//   flush_i     drop all entries
//   push_i      write data_i
//   pop_i       advance head (ignored when empty)
//   data_o      head entry (0-cycle read)
//   count_o     number of valid entries, 0..DEPTH
module dsp_fetch_queue #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [DATA_W-1:0]      data_i,
  input  logic                   pop_i,
  output logic [DATA_W-1:0]      data_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(do_pop);
    end
  end

  // Credit throttling upstream guarantees a full queue is never pushed without a pop.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && !flush_i && !do_pop && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/dsp_fetch.sv
// Instruction fetch stage: holds the PC, issues in-order reads to instruction
// memory under a credit limit of QDEPTH, queues returned words with their pc
// and presents them to decode. A jump redirects the PC, flushes the queue and
// drops responses still in flight.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   jump_flag, jump_addr   redirect request from the branch unit
//   bus (master)           imem request/response and decode instruction channel
// Optional build macro DSP_FETCH_PERF_EN adds saturating counters:
//   perf_redirects         number of jumps taken
//   perf_starve            cycles with no instruction for decode (outside HOLD)
module dsp_fetch
  import dsp_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned INSTR_W  = INSTR_W_DEF,
  parameter int unsigned RESET_PC = RESET_PC_DEF,
  parameter int unsigned QDEPTH   = QDEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              jump_flag,
  input  logic [ADDR_W-1:0] jump_addr,
  dsp_fetch_if.master       bus
`ifdef DSP_FETCH_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_redirects,
  output logic [PERF_W-1:0] perf_starve
`endif
);

  localparam int unsigned CNT_W = cnt_w(QDEPTH);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned ENT_W = ADDR_W + INSTR_W;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic [CNT_W-1:0]  out_cnt;
  logic [CNT_W-1:0]  q_cnt;
  logic [SUM_W-1:0]  inflight;
  logic              jmp, acc, rsp, push, pop;
  logic [ADDR_W-1:0] rsp_pc;
  logic [ENT_W-1:0]  head;

  assign jmp      = jump_flag && (state_q != FETCH_ST_HOLD);
  assign inflight = {1'b0, q_cnt} + {1'b0, out_cnt};

  assign bus.imem_req_valid = (state_q != FETCH_ST_HOLD) && !jump_flag &&
                              (inflight < SUM_W'(QDEPTH));
  assign bus.imem_addr      = pc_q;

  assign acc = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp = bus.imem_rsp_valid;
  // A jump wins over a pending pop: the queue is being flushed anyway.
  assign pop = bus.instr_valid && bus.instr_ready && !jmp;

  // Next PC, drop counter, response routing and FSM transition.
  always_comb begin
    pc_d    = pc_q;
    drop_d  = drop_q;
    push    = 1'b0;
    state_d = state_q;
    if (jmp) begin
      // Everything still in flight after this cycle's response is stale.
      pc_d   = jump_addr;
      drop_d = out_cnt - CNT_W'(rsp);
    end else begin
      if (rsp) begin
        if (drop_q != '0) drop_d = drop_q - CNT_W'(1);
        else              push   = 1'b1;
      end
      if (acc) pc_d = pc_q + ADDR_W'(1);
    end
    if (state_q == FETCH_ST_HOLD) state_d = FETCH_ST_RUN;
    else if (drop_d != '0)        state_d = FETCH_ST_FLUSH;
    else                          state_d = FETCH_ST_RUN;
  end

  // FSM, PC and drop counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH_ST_HOLD;
      pc_q    <= ADDR_W'(RESET_PC);
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

  // pc of every accepted request; its occupancy is the outstanding count.
  dsp_fetch_queue #(.DATA_W(ADDR_W), .DEPTH(QDEPTH)) u_pc_shadow (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (1'b0),
    .push_i  (acc),
    .data_i  (pc_q),
    .pop_i   (rsp),
    .data_o  (rsp_pc),
    .count_o (out_cnt)
  );

  // Instruction queue holding {pc, word} for decode.
  dsp_fetch_queue #(.DATA_W(ENT_W), .DEPTH(QDEPTH)) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (jmp),
    .push_i  (push),
    .data_i  ({rsp_pc, bus.imem_rsp_data}),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (q_cnt)
  );

  assign bus.instr_valid = (q_cnt != '0);
  assign bus.instr       = head[INSTR_W-1:0];
  assign bus.instr_pc    = head[ENT_W-1:INSTR_W];

  a_rsp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
    rsp |-> (out_cnt != '0));

`ifdef DSP_FETCH_PERF_EN
  logic [PERF_W-1:0] redir_q, starve_q;

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      redir_q  <= '0;
      starve_q <= '0;
    end else begin
      if (jmp && (redir_q != '1)) redir_q <= redir_q + PERF_W'(1);
      if (!bus.instr_valid && (state_q != FETCH_ST_HOLD) && (starve_q != '1))
        starve_q <= starve_q + PERF_W'(1);
    end
  end

  assign perf_redirects = redir_q;
  assign perf_starve    = starve_q;
`endif

endmodule
